viterbi_ber_checker: RTL

VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

---
 rtl/viterbi_ber_checker_if.sv | 30 +++
 rtl/viterbi_ber_checker.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/viterbi_ber_checker_if.sv
// Bundle of the data, control and status signals of viterbi_ber_checker.
//   master : drives ref_i, ref_valid_i, dec_i, start_i and win_len_i.
//            Receives busy_o, done_o, bit_ct_o, err_ct_o, max_run_o and sat_o.
//   slave  : the checker side, with the opposite directions.
// CNT_W must match the CNT_W of the checker that is connected to it.
interface viterbi_ber_checker_if #(
  parameter int CNT_W = 16
);
  logic             ref_i;
  logic             ref_valid_i;
  logic             dec_i;
  logic             start_i;
  logic [CNT_W-1:0] win_len_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] bit_ct_o;
  logic [CNT_W-1:0] err_ct_o;
  logic [7:0]       max_run_o;
  logic             sat_o;

  modport master (
    output ref_i, ref_valid_i, dec_i, start_i, win_len_i,
    input  busy_o, done_o, bit_ct_o, err_ct_o, max_run_o, sat_o
  );

  modport slave (
    input  ref_i, ref_valid_i, dec_i, start_i, win_len_i,
    output busy_o, done_o, bit_ct_o, err_ct_o, max_run_o, sat_o
  );
endinterface

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for a Viterbi decoder.
// Source bits (ref_i) are delayed by DELAY valid samples to line them up with
// the decoder output (dec_i). After start_i, the checker skips DELAY samples
// (ALIGN). It then compares win_len_i samples (COUNT), counting bits, errors,
// the longest run of errors and sticky error saturation. Then it parks in DONE.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : viterbi_ber_checker_if slave modport
//         inputs : ref_i, ref_valid_i, dec_i, start_i, win_len_i
//         outputs: busy_o, done_o, bit_ct_o, err_ct_o, max_run_o, sat_o
module viterbi_ber_checker #(
  parameter int DELAY = 32,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_ber_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, COUNT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [8:0]       DELAY_9 = 9'(DELAY);

  state_t           state, state_nxt;
  logic [DELAY-1:0] dly;
  logic             ref_d;
  logic [7:0]       align_ct;
  logic             align_end;
  logic [CNT_W-1:0] win_len_q;
  logic [CNT_W-1:0] bit_ct, bit_ct_inc;
  logic [CNT_W-1:0] err_ct, err_ct_inc;
  logic [7:0]       run_ct, run_inc;
  logic [7:0]       max_run;
  logic             sat;
  logic             done;
  logic             busy;
  logic             mismatch;
  logic             win_end;

  // dly[k] holds the sample that arrived k+1 valid samples ago, so the top
  // tap is exactly DELAY samples old when the current sample is compared.
  assign ref_d      = dly[DELAY-1];
  assign mismatch   = bus.dec_i ^ ref_d;
  assign bit_ct_inc = bit_ct + 1'b1;
  assign err_ct_inc = (err_ct == CNT_MAX) ? err_ct : err_ct + 1'b1;
  assign run_inc    = (run_ct == 8'hFF) ? run_ct : run_ct + 8'd1;

  // The current valid sample is the DELAY-th sample that is skipped. The
  // sample taken in the start cycle is already included in align_ct.
  assign align_end = bus.ref_valid_i && (({1'b0, align_ct} + 9'd1) >= DELAY_9);
  assign win_end   = bus.ref_valid_i && (bit_ct_inc == win_len_q);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers are always assigned with <= so that every flop samples
    // the values from before the edge, whatever the order of the statements.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment comes first so that a path through the
    // case that does not assign state_nxt cannot infer a latch.
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start_i) state_nxt = ALIGN;
      ALIGN:      if (align_end)   state_nxt = (win_len_q == '0) ? DONE : COUNT;
      COUNT:      if (win_end)     state_nxt = DONE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Output decode (from the registered state only).
  always_comb begin
    busy = (state == ALIGN) || (state == COUNT);
  end

  // Reference delay line. It shifts in every state.
  always_ff @(posedge clk) begin
    // NOTE: the delay line is reset on purpose, so that comparisons right
    // after reset see zeros and not leftover bits. The cost is a reset mux on
    // every tap.
    if (rst) begin
      dly <= '0;
    end else if (bus.ref_valid_i) begin
      dly[0] <= bus.ref_i;
      for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  // Measurement datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      align_ct  <= '0;
      win_len_q <= '0;
      bit_ct    <= '0;
      err_ct    <= '0;
      run_ct    <= '0;
      max_run   <= '0;
      sat       <= 1'b0;
    end else begin
      // One-cycle pulse, only on entry to DONE.
      done <= (state != DONE) && (state_nxt == DONE);
      case (state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            bit_ct    <= '0;
            err_ct    <= '0;
            run_ct    <= '0;
            max_run   <= '0;
            sat       <= 1'b0;
            align_ct  <= bus.ref_valid_i ? 8'd1 : 8'd0;
            win_len_q <= bus.win_len_i;
          end
        end
        ALIGN: begin
          if (bus.ref_valid_i) align_ct <= align_ct + 8'd1;
        end
        COUNT: begin
          if (bus.ref_valid_i) begin
            bit_ct <= bit_ct_inc;
            if (mismatch) begin
              err_ct <= err_ct_inc;
              if (err_ct_inc == CNT_MAX) sat <= 1'b1;
              run_ct <= run_inc;
              if (run_inc > max_run) max_run <= run_inc;
            end else begin
              run_ct <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.bit_ct_o  = bit_ct;
  assign bus.err_ct_o  = err_ct;
  assign bus.max_run_o = max_run;
  assign bus.sat_o     = sat;

endmodule
